// File: rtl/bcd_stopwatch_mux.sv
// BCD stopwatch/countdown with lap freeze and scanned 7-segment driver; button edges act 3 cycles after input rise.
// Count updates the cycle after a tick; no backpressure, AN/SEG are registered and refreshed every cycle.
module bcd_stopwatch_mux #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 100,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 4
) (
  input  logic                  CLK_100M,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CLEAR,
  input  logic                  LAP,
  input  logic                  LOAD,
  input  logic                  DIR,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  RUN,
  output logic                  HOLD,
  output logic                  TC
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = 4 * DIGITS;

  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_CLEAR = 2;
  localparam int B_LAP   = 3;
  localparam int B_LOAD  = 4;
  localparam int B_DIR   = 5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXP} state_t;

  state_t          state_q, state_d;
  logic [5:0]      meta_q, sync_q;
  logic [4:0]      prev_q;
  logic [4:0]      edge_s;
  logic            dir_s;
  logic [TW-1:0]   tick_cnt_q;
  logic            tick;
  logic [SW-1:0]   scan_cnt_q;
  logic            scan_wrap;
  logic [NW-1:0]   count_q, count_d;
  logic [NW-1:0]   disp_q, disp_d;
  logic            hold_q, hold_d;
  logic            tc_q, tc_d;
  logic [NW-1:0]   cnt_inc, cnt_dec, load_clamped, disp_live;
  logic            carry, borrow, dec_zero;
  logic [IW-1:0]   idx_q, idx_d;
  logic            on_q, on_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      nib;

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 8'h03;
      4'd1:    seg_of = 8'h9F;
      4'd2:    seg_of = 8'h25;
      4'd3:    seg_of = 8'h0D;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h49;
      4'd6:    seg_of = 8'h41;
      4'd7:    seg_of = 8'h1F;
      4'd8:    seg_of = 8'h01;
      4'd9:    seg_of = 8'h09;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  assign edge_s    = sync_q[4:0] & ~prev_q;
  assign dir_s     = sync_q[B_DIR];
  assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign scan_wrap = (scan_cnt_q == SW'(SCAN_DIV - 1));

  // BCD increment/decrement with ripple carry/borrow, plus preset clamping
  always_comb begin
    cnt_inc      = count_q;
    cnt_dec      = count_q;
    load_clamped = LOAD_VAL;
    carry        = 1'b1;
    borrow       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (LOAD_VAL[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
    dec_zero = (cnt_dec == '0);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    disp_d  = disp_q;
    hold_d  = hold_q;
    tc_d    = 1'b0;

    if (state_q == S_RUN && tick) begin
      if (!dir_s) begin
        count_d = cnt_inc;
        tc_d    = carry;
      end else begin
        count_d = cnt_dec;
        if (dec_zero) begin
          tc_d    = 1'b1;
          state_d = S_EXP;
        end
      end
    end

    // Only the highest-priority command edge of a cycle is honoured
    if (edge_s[B_CLEAR]) begin
      count_d = '0;
      state_d = S_IDLE;
      tc_d    = 1'b0;
    end else if (edge_s[B_LOAD]) begin
      count_d = load_clamped;
      tc_d    = 1'b0;
      if (state_d == S_EXP) state_d = S_IDLE;
    end else if (edge_s[B_STOP]) begin
      if (state_d == S_RUN) state_d = S_IDLE;
    end else if (edge_s[B_START]) begin
      if (state_q == S_IDLE) state_d = S_RUN;
    end

    if (edge_s[B_CLEAR]) begin
      hold_d = 1'b0;
    end else if (edge_s[B_LAP]) begin
      if (!hold_q) begin
        disp_d = count_q;
        hold_d = 1'b1;
      end else begin
        hold_d = 1'b0;
      end
    end
  end

  // Scan index stays parked (anodes dark) until the first divider wrap after reset
  always_comb begin
    idx_d = idx_q;
    on_d  = on_q;
    if (scan_wrap) begin
      if (!on_q)                            on_d  = 1'b1;
      else if (idx_q == IW'(DIGITS - 1))    idx_d = '0;
      else                                  idx_d = idx_q + IW'(1);
    end
    disp_live = hold_q ? disp_q : count_q;
    nib       = disp_live[{idx_d, 2'b00} +: 4];
    an_d      = on_d ? ~(DIGITS'(1) << idx_d) : '1;
    seg_d     = on_d ? seg_of(nib) : 8'hFF;
  end

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      meta_q     <= '0;
      sync_q     <= '0;
      prev_q     <= '0;
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      state_q    <= S_IDLE;
      count_q    <= '0;
      disp_q     <= '0;
      hold_q     <= 1'b0;
      tc_q       <= 1'b0;
      idx_q      <= '0;
      on_q       <= 1'b0;
      an_q       <= '1;
      seg_q      <= 8'hFF;
    end else begin
      meta_q     <= {DIR, LOAD, LAP, CLEAR, STOP, START};
      sync_q     <= meta_q;
      prev_q     <= sync_q[4:0];
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + SW'(1);
      state_q    <= state_d;
      count_q    <= count_d;
      disp_q     <= disp_d;
      hold_q     <= hold_d;
      tc_q       <= tc_d;
      idx_q      <= idx_d;
      on_q       <= on_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign RUN  = (state_q == S_RUN);
  assign HOLD = hold_q;
  assign TC   = tc_q;
  assign AN   = an_q;
  assign SEG  = seg_q;

endmodule
